// File: rtl/ebpc_pkg.sv
// ============================================================================
//  Module   : ebpc_pkg
//  Brief    : Shared constants and types for the encoder front end.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package ebpc_pkg;

    localparam int unsigned DATA_W        = 16;
    localparam int unsigned LOG_MAX_BLOCK = 12;
    localparam int unsigned BLK_CNT_W     = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2
    } ctrl_state_t;

endpackage

`default_nettype wire

// File: rtl/zrle_block_ctrl_if.sv
// ============================================================================
//  Module   : zrle_block_ctrl_if
//  Brief    : Input stream, ZRLE and nonzero-stream signals of the block ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

interface zrle_block_ctrl_if;

    logic [ebpc_pkg::LOG_MAX_BLOCK-1:0] block_len_i;
    logic [ebpc_pkg::DATA_W-1:0]        data_i;
    logic                               last_i;
    logic                               vld_i;
    logic                               rdy_o;
    logic                               zrle_is_one_o;
    logic                               zrle_flush_o;
    logic                               zrle_vld_o;
    logic                               zrle_rdy_i;
    logic                               zrle_out_vld_i;
    logic                               zrle_out_rdy_i;
    logic                               zrle_out_last_i;
    logic [ebpc_pkg::DATA_W-1:0]        nz_data_o;
    logic                               nz_last_o;
    logic                               nz_vld_o;
    logic                               nz_rdy_i;
    logic [ebpc_pkg::BLK_CNT_W-1:0]     blk_cnt_o;
    logic                               idle_o;

    modport master (
        input  block_len_i, data_i, last_i, vld_i,
        input  zrle_rdy_i, zrle_out_vld_i, zrle_out_rdy_i, zrle_out_last_i,
        input  nz_rdy_i,
        output rdy_o, zrle_is_one_o, zrle_flush_o, zrle_vld_o,
        output nz_data_o, nz_last_o, nz_vld_o, blk_cnt_o, idle_o
    );

    modport slave (
        output block_len_i, data_i, last_i, vld_i,
        output zrle_rdy_i, zrle_out_vld_i, zrle_out_rdy_i, zrle_out_last_i,
        output nz_rdy_i,
        input  rdy_o, zrle_is_one_o, zrle_flush_o, zrle_vld_o,
        input  nz_data_o, nz_last_o, nz_vld_o, blk_cnt_o, idle_o
    );

endinterface

`default_nettype wire

// File: rtl/zrle_block_ctrl.sv
// ============================================================================
//  Module   : zrle_block_ctrl
//  Brief    : Per-block sequencer feeding the ZRLE and the nonzero BPC stream.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module zrle_block_ctrl
    import ebpc_pkg::*;
(
    input  logic              clk_i,
    input  logic              rst_ni,
    zrle_block_ctrl_if.master ctrl
);

    localparam logic [LOG_MAX_BLOCK:0] c_len_one = (LOG_MAX_BLOCK+1)'(1);
    localparam logic [LOG_MAX_BLOCK:0] c_len_max = {1'b1, {LOG_MAX_BLOCK{1'b0}}};

    ctrl_state_t               r_state;
    logic [LOG_MAX_BLOCK:0]    r_len_q;
    logic [LOG_MAX_BLOCK-1:0]  r_word_cnt;
    logic [BLK_CNT_W-1:0]      r_blk_cnt;

    logic w_nz;
    logic w_end_blk;
    logic w_rdy;
    logic w_xfer;
    logic w_last_hs;

    // Both sinks are joined: a nonzero word needs both ready, a zero word only the ZRLE.
    always_comb begin
        w_nz      = (ctrl.data_i != '0);
        w_end_blk = ctrl.last_i || (({1'b0, r_word_cnt} + c_len_one) == r_len_q);
        w_rdy     = 1'b0;
        w_last_hs = ctrl.zrle_out_vld_i && ctrl.zrle_out_rdy_i && ctrl.zrle_out_last_i;

        ctrl.zrle_vld_o    = 1'b0;
        ctrl.zrle_is_one_o = 1'b0;
        ctrl.zrle_flush_o  = 1'b0;
        ctrl.nz_vld_o      = 1'b0;
        ctrl.nz_last_o     = 1'b0;
        ctrl.nz_data_o     = ctrl.data_i;
        ctrl.idle_o        = 1'b0;

        case (r_state)
            IDLE: begin
                ctrl.idle_o = !ctrl.vld_i;
            end
            RUN: begin
                w_rdy              = ctrl.zrle_rdy_i && (!w_nz || ctrl.nz_rdy_i);
                ctrl.zrle_vld_o    = ctrl.vld_i && (!w_nz || ctrl.nz_rdy_i);
                ctrl.zrle_is_one_o = w_nz;
                ctrl.zrle_flush_o  = w_end_blk;
                ctrl.nz_vld_o      = ctrl.vld_i && w_nz && ctrl.zrle_rdy_i;
                ctrl.nz_last_o     = w_end_blk;
            end
            default: ;
        endcase

        ctrl.rdy_o = w_rdy;
        w_xfer     = ctrl.vld_i && w_rdy;
    end

    assign ctrl.blk_cnt_o = r_blk_cnt;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_state    <= IDLE;
            r_len_q    <= '0;
            r_word_cnt <= '0;
            r_blk_cnt  <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (ctrl.vld_i) begin
                        r_len_q    <= (ctrl.block_len_i == '0) ? c_len_max
                                                               : {1'b0, ctrl.block_len_i};
                        r_word_cnt <= '0;
                        r_state    <= RUN;
                    end
                end
                RUN: begin
                    if (w_xfer) begin
                        r_word_cnt <= r_word_cnt + LOG_MAX_BLOCK'(1);
                        if (w_end_blk) begin
                            r_state <= DRAIN;
                        end
                    end
                end
                DRAIN: begin
                    if (w_last_hs) begin
                        r_blk_cnt <= r_blk_cnt + BLK_CNT_W'(1);
                        r_state   <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_zrle_block_ctrl.sv
// ============================================================================
//  Module   : tb_zrle_block_ctrl
//  Brief    : Directed self-checking bench for zrle_block_ctrl.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module tb_zrle_block_ctrl;
    import ebpc_pkg::*;

    logic clk_i;
    logic rst_ni;
    int   n_cmp;
    int   n_err;

    logic [1:0]  sym_q[$];   // {flush, is_one}
    logic [16:0] nz_q[$];    // {last, data}

    zrle_block_ctrl_if bus();

    zrle_block_ctrl dut (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .ctrl   (bus)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    initial begin
        #1ms;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Handshakes are stable from negedge to the following posedge.
    always @(negedge clk_i) begin
        if (bus.zrle_vld_o && bus.zrle_rdy_i)
            sym_q.push_back({bus.zrle_flush_o, bus.zrle_is_one_o});
        if (bus.nz_vld_o && bus.nz_rdy_i)
            nz_q.push_back({bus.nz_last_o, bus.nz_data_o});
        if (bus.zrle_vld_o && bus.zrle_rdy_i && bus.zrle_flush_o)
            assert (!(bus.zrle_out_vld_i && bus.zrle_out_rdy_i && bus.zrle_out_last_i))
                else $error("FAIL flush_overlap: last-handshake with flush transfer");
        if (dut.r_state != DRAIN)
            assert (!(bus.zrle_out_vld_i && bus.zrle_out_rdy_i && bus.zrle_out_last_i))
                else $error("FAIL snoop_last: last-handshake outside DRAIN");
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic send_word(input logic [15:0] d, input logic l);
        int n;
        bus.data_i = d;
        bus.last_i = l;
        bus.vld_i  = 1'b1;
        n = 0;
        @(negedge clk_i);
        while (!bus.rdy_o && n < 100) begin
            n++;
            @(negedge clk_i);
        end
        if (n >= 100) check_eq("send_timeout", 32'(bus.rdy_o), 32'd1);
        @(posedge clk_i);
        #1;
        bus.vld_i  = 1'b0;
        bus.last_i = 1'b0;
    endtask

    task automatic drain_block(input string tag, input int exp_blk);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk_i);
            check_eq({tag, "_drain_rdy"}, 32'(bus.rdy_o), 32'd0);
        end
        check_eq({tag, "_drain_vld"}, 32'({bus.zrle_vld_o, bus.nz_vld_o}), 32'd0);
        @(posedge clk_i); #1;
        bus.zrle_out_vld_i  = 1'b1;
        bus.zrle_out_rdy_i  = 1'b1;
        bus.zrle_out_last_i = 1'b0;
        @(posedge clk_i); #1;
        check_eq({tag, "_nolast_blk"}, 32'(bus.blk_cnt_o), 32'(exp_blk - 1));
        bus.zrle_out_last_i = 1'b1;
        @(posedge clk_i); #1;
        bus.zrle_out_vld_i  = 1'b0;
        bus.zrle_out_rdy_i  = 1'b0;
        bus.zrle_out_last_i = 1'b0;
        @(negedge clk_i);
        check_eq({tag, "_blk_cnt"}, 32'(bus.blk_cnt_o), 32'(exp_blk));
        check_eq({tag, "_idle"}, 32'(bus.idle_o), 32'd1);
    endtask

    task automatic check_syms(input string tag, input logic [1:0] exp[]);
        check_eq({tag, "_sym_n"}, 32'(sym_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < sym_q.size(); i++)
            check_eq($sformatf("%s_sym%0d", tag, i), 32'(sym_q[i]), 32'(exp[i]));
    endtask

    task automatic check_nz(input string tag, input logic [16:0] exp[]);
        check_eq({tag, "_nz_n"}, 32'(nz_q.size()), 32'(exp.size()));
        for (int i = 0; i < exp.size() && i < nz_q.size(); i++)
            check_eq($sformatf("%s_nz%0d", tag, i), 32'(nz_q[i]), 32'(exp[i]));
    endtask

    initial begin
        int n_flush;
        int flush_idx;
        n_cmp = 0;
        n_err = 0;
        rst_ni              = 1'b0;
        bus.block_len_i     = '0;
        bus.data_i          = '0;
        bus.last_i          = 1'b0;
        bus.vld_i           = 1'b0;
        bus.zrle_rdy_i      = 1'b1;
        bus.nz_rdy_i        = 1'b1;
        bus.zrle_out_vld_i  = 1'b0;
        bus.zrle_out_rdy_i  = 1'b0;
        bus.zrle_out_last_i = 1'b0;
        repeat (3) @(posedge clk_i);
        #1 rst_ni = 1'b1;

        @(negedge clk_i);
        check_eq("rst_outs", 32'({bus.rdy_o, bus.zrle_vld_o, bus.zrle_flush_o,
                                  bus.nz_vld_o, bus.nz_last_o}), 32'd0);
        check_eq("rst_blk_cnt", 32'(bus.blk_cnt_o), 32'd0);
        check_eq("rst_idle", 32'(bus.idle_o), 32'd1);

        // Block 1: len 4, words 0,5,0,7
        sym_q.delete(); nz_q.delete();
        bus.block_len_i = 12'd4;
        @(posedge clk_i); #1;
        bus.data_i = 16'd0; bus.vld_i = 1'b1;
        @(negedge clk_i);
        check_eq("t1_bubble_rdy", 32'(bus.rdy_o), 32'd0);
        check_eq("t1_bubble_idle", 32'(bus.idle_o), 32'd0);
        send_word(16'd0, 1'b0);
        send_word(16'd5, 1'b0);
        send_word(16'd0, 1'b0);
        send_word(16'd7, 1'b0);
        check_syms("t1", '{2'b00, 2'b01, 2'b00, 2'b11});
        check_nz("t1", '{{1'b0, 16'd5}, {1'b1, 16'd7}});
        drain_block("t1", 1);

        // Block 2: len 3, words 1,2,3 with nz sink stalled on word 2
        sym_q.delete(); nz_q.delete();
        bus.block_len_i = 12'd3;
        send_word(16'd1, 1'b0);
        bus.nz_rdy_i = 1'b0;
        bus.data_i   = 16'd2;
        bus.vld_i    = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk_i);
            check_eq($sformatf("t2_stall_zvld%0d", i), 32'(bus.zrle_vld_o), 32'd0);
        end
        check_eq("t2_stall_nzvld", 32'(bus.nz_vld_o), 32'd1);
        @(posedge clk_i); #1;
        bus.nz_rdy_i = 1'b1;
        send_word(16'd2, 1'b0);
        send_word(16'd3, 1'b0);
        check_syms("t2", '{2'b01, 2'b01, 2'b11});
        check_nz("t2", '{{1'b0, 16'd1}, {1'b0, 16'd2}, {1'b1, 16'd3}});
        drain_block("t2", 2);

        // Block 3: len 8, zeros, last_i on the third word
        sym_q.delete(); nz_q.delete();
        bus.block_len_i = 12'd8;
        send_word(16'd0, 1'b0);
        send_word(16'd0, 1'b0);
        send_word(16'd0, 1'b1);
        check_syms("t3", '{2'b00, 2'b00, 2'b10});
        check_eq("t3_nz_n", 32'(nz_q.size()), 32'd0);
        drain_block("t3", 3);

        // Block 4: len 0 means 4096 words
        sym_q.delete(); nz_q.delete();
        bus.block_len_i = 12'd0;
        for (int i = 0; i < 4096; i++) send_word(16'd0, 1'b0);
        n_flush   = 0;
        flush_idx = -1;
        foreach (sym_q[i]) if (sym_q[i][1]) begin
            n_flush++;
            if (flush_idx < 0) flush_idx = i;
        end
        check_eq("t4_sym_n", 32'(sym_q.size()), 32'd4096);
        check_eq("t4_flush_n", 32'(n_flush), 32'd1);
        check_eq("t4_flush_idx", 32'(flush_idx), 32'd4095);
        check_eq("t4_nz_n", 32'(nz_q.size()), 32'd0);
        drain_block("t4", 4);

        // Block 5/6: length changed mid-block only takes effect next block
        sym_q.delete(); nz_q.delete();
        bus.block_len_i = 12'd4;
        send_word(16'd1, 1'b0);
        send_word(16'd0, 1'b0);
        bus.block_len_i = 12'd2;
        send_word(16'd0, 1'b0);
        send_word(16'd3, 1'b0);
        check_syms("t5a", '{2'b01, 2'b00, 2'b00, 2'b11});
        drain_block("t5a", 5);
        sym_q.delete(); nz_q.delete();
        send_word(16'd0, 1'b0);
        send_word(16'd4, 1'b0);
        check_syms("t5b", '{2'b00, 2'b11});
        check_nz("t5b", '{{1'b1, 16'd4}});
        drain_block("t5b", 6);

        // Async reset in the middle of a block
        sym_q.delete(); nz_q.delete();
        bus.block_len_i = 12'd4;
        send_word(16'd9, 1'b0);
        send_word(16'd0, 1'b0);
        bus.data_i = 16'd8;
        bus.vld_i  = 1'b1;
        @(negedge clk_i);
        check_eq("t6_pre_vld", 32'({bus.zrle_vld_o, bus.nz_vld_o}), 32'd3);
        #2 rst_ni = 1'b0;
        #1;
        check_eq("t6_rst_vld", 32'({bus.zrle_vld_o, bus.nz_vld_o, bus.rdy_o}), 32'd0);
        check_eq("t6_rst_state", 32'(dut.r_state), 32'(IDLE));
        check_eq("t6_rst_blk", 32'(bus.blk_cnt_o), 32'd0);
        bus.vld_i = 1'b0;
        #1;
        check_eq("t6_rst_idle", 32'(bus.idle_o), 32'd1);
        @(posedge clk_i); #1;
        rst_ni = 1'b1;
        sym_q.delete(); nz_q.delete();
        bus.block_len_i = 12'd2;
        send_word(16'd6, 1'b0);
        send_word(16'd0, 1'b0);
        check_syms("t6", '{2'b01, 2'b10});
        check_nz("t6", '{{1'b0, 16'd6}});
        drain_block("t6", 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
